// File: rtl/colour_scan_pkg.sv
// colour_scan_pkg: shared state, threshold types and defaults for the colour scan controller
package colour_scan_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN} scan_state_t;
  typedef struct packed {
    logic [3:0] upper;
    logic [3:0] lower;
  } thresh_t;
  localparam logic [3:0] DEFAULT_UPPER = 4'h8;
  localparam logic [3:0] DEFAULT_LOWER = 4'h3;
  localparam int FRAME_PIXELS = 76800;
  localparam thresh_t DEFAULT_THRESH = '{upper: DEFAULT_UPPER, lower: DEFAULT_LOWER};
endpackage

// File: rtl/colour_scan_slot_hysteresis.sv
// slot_hysteresis: saturating hit/miss counter that debounces one slot's detection
module slot_hysteresis #(
  parameter int PERSIST = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hit,
  input  logic strobe,
  output logic detected
);
  localparam int CW = $clog2(PERSIST + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  always_comb
    cnt_nxt = !strobe ? cnt
            : hit ? (cnt == CW'(PERSIST) ? cnt : cnt + 1'b1)
            : (cnt == '0 ? cnt : cnt - 1'b1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt      <= '0;
      detected <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      detected <= cnt_nxt == CW'(PERSIST) ? 1'b1 : cnt_nxt == '0 ? 1'b0 : detected;
    end
endmodule

// File: rtl/colour_scan_ctrl.sv
// colour_scan_ctrl: round-robin colour target scanner, one slot per frame, with per-slot hysteresis.
// Optional watchdog enabled by defining COLOUR_SCAN_TIMEOUT_EN.
module colour_scan_ctrl
  import colour_scan_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int MIN_PIXELS     = FRAME_PIXELS * 4 / 5,
  parameter int PERSIST        = 3,
  parameter int TIMEOUT_CYCLES = 2000000,
  localparam int SW            = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 frame_start,
  input  logic [16:0]          count_in,
  input  logic                 cfg_we,
  input  logic [SW-1:0]        cfg_slot,
  input  logic [3:0]           cfg_upper,
  input  logic [3:0]           cfg_lower,
  output logic [3:0]           upper_thresh,
  output logic [3:0]           lower_thresh,
  output logic [SW-1:0]        active_slot,
  output logic                 result_valid,
  output logic [SW-1:0]        result_slot,
  output logic [16:0]          result_count,
  output logic [NUM_SLOTS-1:0] detected,
  output logic                 stall
);
  scan_state_t   state, state_nxt;
  thresh_t       tbl [NUM_SLOTS];
  thresh_t       applied, cfg_val;
  logic          capture, hit, trip, cfg_ok;
  logic [SW-1:0] slot_nxt;
  assign cfg_val      = '{upper: cfg_upper, lower: cfg_lower};
  assign cfg_ok       = cfg_we && ({1'b0, cfg_slot} < (SW+1)'(NUM_SLOTS));
  assign capture      = state == RUN && enable && frame_start;
  assign hit          = count_in > 17'(MIN_PIXELS);
  assign slot_nxt     = active_slot == SW'(NUM_SLOTS - 1) ? '0 : active_slot + 1'b1;
  assign upper_thresh = applied.upper;
  assign lower_thresh = applied.lower;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  always_comb
    state_nxt = !enable ? IDLE
              : trip ? ARM
              : state == IDLE ? ARM
              : (state == ARM && frame_start) ? RUN
              : state;
  // A write aimed at the slot being switched in wins over the stale table entry.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) tbl[i] <= DEFAULT_THRESH;
      applied      <= DEFAULT_THRESH;
      active_slot  <= '0;
      result_valid <= 1'b0;
      result_slot  <= '0;
      result_count <= '0;
    end else begin
      if (cfg_ok) tbl[cfg_slot] <= cfg_val;
      result_valid <= capture;
      if (capture) begin
        result_slot  <= active_slot;
        result_count <= count_in;
        active_slot  <= slot_nxt;
        applied      <= (cfg_ok && cfg_slot == slot_nxt) ? cfg_val : tbl[slot_nxt];
      end
    end
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_hyst
    slot_hysteresis #(.PERSIST(PERSIST)) u_hyst (
      .clk      (clk),
      .reset_n  (reset_n),
      .hit      (hit),
      .strobe   (capture && active_slot == SW'(k)),
      .detected (detected[k])
    );
  end
`ifdef COLOUR_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  assign trip = state == RUN && enable && !frame_start && wd_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wd_cnt <= '0;
      stall  <= 1'b0;
    end else begin
      wd_cnt <= frame_start ? '0 : wd_cnt == TW'(TIMEOUT_CYCLES) ? wd_cnt : wd_cnt + 1'b1;
      stall  <= frame_start ? 1'b0 : trip ? 1'b1 : stall;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign trip  = 1'b0;
  assign stall = 1'b0;
`endif
endmodule
